// File: rtl/acc_pkg.sv
// acc_drain shared package: FSM encoding, accumulator width, default sizes.
package acc_pkg;
   localparam int ACC_W      = 6;
   localparam int WRAP_W_DEF = 4;
   localparam int DEPTH_DEF  = 4;
   localparam int PERIOD_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered head, no fall-through; push on a full FIFO
// succeeds only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign o_empty = (cnt_q == '0);
   assign o_full  = (cnt_q == (AW+1)'(DEPTH));
   // Head reads as zero when empty so the output is clean out of reset.
   assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = i_pop && !o_empty;
      do_push  = i_push && (!o_full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= i_data;
   end
endmodule

// File: rtl/acc_drain.sv
// Periodic sampler of {wrap_cnt, acc} into an output FIFO with drain.
// Optional ACC_DRAIN_DROP_CNT_EN adds a saturating lost-sample counter.
module acc_drain
   import acc_pkg::*;
#(
   parameter int WRAP_W = WRAP_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PERIOD = PERIOD_DEF
) (
   input  logic                    clk,
   input  logic                    i_rst,
   input  logic [ACC_W-1:0]        i_acc,
   input  logic                    i_carry,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic                    i_clear,
   output logic [WRAP_W+ACC_W-1:0] o_data,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_drop
`ifdef ACC_DRAIN_DROP_CNT_EN
   ,
   output logic [7:0]              o_drop_cnt
`endif
);
   localparam int PER_W = $clog2(PERIOD);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);

   state_e            state_q, state_d;
   logic [WRAP_W-1:0] wrap_q, wrap_d;
   logic [PER_W-1:0]  per_q, per_d;
   logic              drop_q, drop_d;
   logic              sample, push, pop, lost, go_run;
   logic              fifo_full, fifo_empty;

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      wrap_d  = wrap_q;
      drop_d  = drop_q;
      sample  = 1'b0;
      go_run  = 1'b0;
      if (i_clear)      wrap_d = '0;
      else if (i_carry) wrap_d = wrap_q + 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = ST_RUN;
               per_d   = '0;
               go_run  = 1'b1;
            end
         end
         ST_RUN: begin
            // A stop wins over a coincident sample, which is discarded.
            if (i_stop) begin
               state_d = ST_DRAIN;
            end else if (per_q == PER_LAST) begin
               per_d  = '0;
               sample = 1'b1;
            end else begin
               per_d = per_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      pop  = !fifo_empty && i_ready;
      push = sample && (!fifo_full || pop);
      lost = sample && fifo_full && !pop;
      if (go_run)    drop_d = 1'b0;
      else if (lost) drop_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         wrap_q  <= '0;
         per_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wrap_q  <= wrap_d;
         per_q   <= per_d;
         drop_q  <= drop_d;
      end
   end

`ifdef ACC_DRAIN_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (go_run)                          drop_cnt_d = '0;
      else if (lost && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (i_rst) drop_cnt_q <= '0;
      else       drop_cnt_q <= drop_cnt_d;
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

   sync_fifo #(
      .WIDTH (WRAP_W + ACC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_data  ({wrap_q, i_acc}),
      .i_pop   (pop),
      .o_data  (o_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign o_valid = !fifo_empty;
   assign o_busy  = (state_q != ST_IDLE);
   assign o_drop  = drop_q;
endmodule

// File: doc/acc_drain.md
ACC_DRAIN -- requirements
Module: acc_drain

Interface
REQ-001 SHALL have parameter WRAP_W, default 4: width of the carry-wrap counter.
REQ-002 SHALL have parameter DEPTH, default 4: number of output FIFO entries (power of 2, minimum 2).
REQ-003 SHALL have parameter PERIOD, default 8: cycles between samples in RUN (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_acc, input, 6 bits: registered output of the upstream accumulator.
REQ-007 SHALL have port i_carry, input, 1 bit: upstream adder carry; high means i_acc wraps at this edge.
REQ-008 SHALL have ports i_start and i_stop, input, 1 bit each: one-cycle control pulses.
REQ-009 SHALL have port i_clear, input, 1 bit: pulse that zeroes the wrap counter.
REQ-010 SHALL have port o_data, output, WRAP_W+6 bits: FIFO head, {wrap_cnt, acc}.
REQ-011 SHALL have port o_valid, output, 1 bit: asserted when the FIFO is non-empty.
REQ-012 SHALL have port i_ready, input, 1 bit: downstream accepts o_data when o_valid and i_ready are both high.
REQ-013 SHALL have port o_busy, output, 1 bit: asserted in RUN or DRAIN.
REQ-014 SHALL have port o_drop, output, 1 bit: sticky; set when a sample is lost.

Function
REQ-015 SHALL increment wrap_cnt modulo 2^WRAP_W on every edge with i_carry=1, in every state.
REQ-016 SHALL give i_clear priority over i_carry in the same cycle: wrap_cnt becomes 0.
REQ-017 SHALL implement an FSM with states IDLE, RUN and DRAIN; the state after reset is IDLE.
REQ-018 SHALL move IDLE->RUN on i_start; at the same edge the period counter loads 0.
REQ-019 SHALL generate a sample in RUN when the period counter equals PERIOD-1; the counter then wraps to 0; the first sample comes PERIOD cycles after entry.
REQ-020 SHALL capture each sample as {wrap_cnt, i_acc} using the values present before that edge's update.
REQ-021 SHALL move RUN->DRAIN on i_stop; i_stop beats a coincident sample, and that sample is discarded without setting o_drop.
REQ-022 SHALL move DRAIN->IDLE on the cycle the FIFO is empty; i_start is ignored in DRAIN and in RUN.
REQ-023 SHALL ignore i_stop in IDLE.
REQ-024 SHALL discard a sample that arrives while the FIFO is full, unless a pop happens in the same cycle, and SHALL then set o_drop.
REQ-025 SHALL handle a push and pop in the same cycle with the FIFO full by performing both; occupancy stays DEPTH.
REQ-026 SHALL hold o_data stable while o_valid=1 and i_ready=0.
REQ-027 SHALL have a push-to-o_valid latency of 1 cycle when the FIFO is empty; there is no fall-through.
REQ-028 SHALL clear o_drop only by reset or on a IDLE->RUN transition.

Reset
REQ-029 SHALL, on i_rst, bring: state IDLE, wrap_cnt 0, period counter 0, FIFO empty, o_valid 0, o_busy 0, o_drop 0, o_data 0.
REQ-030 SHALL let reset in any state, including mid-DRAIN, discard all FIFO contents with no handshake.

Configuration
REQ-031 SHALL, when ACC_DRAIN_DROP_CNT_EN is defined, add output o_drop_cnt (8 bits, reset 0), incremented per lost sample, saturating at 255, cleared together with o_drop.
REQ-032 SHALL, when ACC_DRAIN_DROP_CNT_EN is undefined, have no o_drop_cnt port; o_drop behaviour is unchanged.

Structure
REQ-033 SHALL place the FSM state encoding, the ACC_W=6 constant and the default parameters in shared package acc_pkg.
REQ-034 SHALL implement the FIFO as sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/full/empty), reusable elsewhere.

Verification
REQ-035 SHALL cover: reset, then i_start, i_acc=5, wrap_cnt=0, i_ready=1 -> o_valid rises at cycle 9 after start with o_data=0x005.
REQ-036 SHALL cover: i_carry pulsed 3 times, i_acc=0x2A at the sample -> o_data=0x0EA; 16 carries with WRAP_W=4 -> wrap_cnt returns to 0.
REQ-037 SHALL cover: i_ready=0 for 6 samples with DEPTH=4 -> 4 entries held, o_drop=1 (o_drop_cnt=2 with the macro); the first entry is popped unchanged.
REQ-038 SHALL cover: i_stop with 3 entries queued, i_ready=1 -> DRAIN for 3 pops, then IDLE; o_busy falls the cycle after the FIFO is empty.
REQ-039 SHALL cover: i_clear and i_carry in the same cycle -> wrap_cnt=0.
REQ-040 SHALL cover: i_rst asserted mid-DRAIN with 2 entries -> next cycle o_valid=0, IDLE, o_drop=0.
